// File: rtl/traffic_signal_rr.sv
// N-direction round-robin traffic-light controller with min/max green, timed yellow and
// an optional all-red clearance phase enabled by defining the ALL_RED_EN macro.
module traffic_signal_rr #(
  parameter int N_DIR       = 2,
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 16,
  parameter int YELLOW_CYC  = 2,
  parameter int ALL_RED_CYC = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           T,
  output logic [2*N_DIR-1:0]         S,
  output logic [$clog2(N_DIR)-1:0]   active,
  output logic [1:0]                 phase
);

  localparam int ACT_W = $clog2(N_DIR);
  localparam int TMR_W = $clog2(MAX_GREEN+1);

  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(MAX_GREEN-1);
  localparam logic [TMR_W-1:0] MIN_LIM = TMR_W'(MIN_GREEN-1);
  localparam logic [TMR_W-1:0] YEL_LIM = TMR_W'(YELLOW_CYC-1);
  localparam logic [TMR_W-1:0] AR_LIM  = TMR_W'(ALL_RED_CYC-1);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10
  } phase_e;

  phase_e             phase_q, phase_n;
  logic [ACT_W-1:0]   active_q, active_n;
  logic [TMR_W-1:0]   tmr_q, tmr_n;

  logic [N_DIR-1:0]   act_onehot;
  logic               self_req;
  logic               others;
  logic [2*N_DIR-1:0] dbl;
  logic [ACT_W-1:0]   nxt;

  // Index active+off reduced modulo N_DIR; off never exceeds N_DIR-1.
  function automatic logic [ACT_W-1:0] wrap_idx(input logic [ACT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_DIR) s = s - N_DIR;
    return ACT_W'(s);
  endfunction

  assign act_onehot = N_DIR'(1) << active_q;
  assign self_req   = |(T & act_onehot);
  assign others     = |(T & ~act_onehot);

  // Rotate the sensors so bit m holds direction (active+1+m) mod N_DIR; lowest set bit wins.
  always_comb begin
    dbl = {T, T} >> ({1'b0, active_q} + (ACT_W+1)'(1));
    nxt = wrap_idx(active_q, 1);
    for (int i = N_DIR-2; i >= 0; i--) begin
      if (dbl[i]) nxt = wrap_idx(active_q, i+1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= GREEN;
      active_q <= '0;
      tmr_q    <= '0;
    end else begin
      phase_q  <= phase_n;
      active_q <= active_n;
      tmr_q    <= tmr_n;
    end
  end

  always_comb begin
    phase_n  = phase_q;
    active_n = active_q;
    tmr_n    = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);
    case (phase_q)
      GREEN: begin
        // Green never times out on its own: preemption needs another requester.
        if (tmr_q >= MIN_LIM && (!self_req || (tmr_q == TMR_SAT && others))) begin
          phase_n = YELLOW;
          tmr_n   = '0;
        end
      end
      YELLOW: begin
        if (tmr_q == YEL_LIM) begin
          tmr_n = '0;
`ifdef ALL_RED_EN
          phase_n = ALL_RED;
`else
          phase_n  = GREEN;
          active_n = nxt;
`endif
        end
      end
      ALL_RED: begin
        if (tmr_q == AR_LIM) begin
          phase_n  = GREEN;
          active_n = nxt;
          tmr_n    = '0;
        end
      end
      default: begin
        phase_n  = GREEN;
        active_n = '0;
        tmr_n    = '0;
      end
    endcase
  end

  always_comb begin
    S = {N_DIR{2'b10}};
    for (int i = 0; i < N_DIR; i++) begin
      if (ACT_W'(i) == active_q) begin
        case (phase_q)
          GREEN:   S[2*i +: 2] = 2'b00;
          YELLOW:  S[2*i +: 2] = 2'b01;
          default: S[2*i +: 2] = 2'b10;
        endcase
      end
    end
  end

  assign active = active_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_signal_rr.sv
// Directed self-checking bench for traffic_signal_rr: a 4-direction and a 2-direction instance.
module tb_traffic_signal_rr;

`ifdef ALL_RED_EN
  localparam int AR4 = 3;
  localparam int AR2 = 1;
`else
  localparam int AR4 = 0;
  localparam int AR2 = 0;
`endif

  logic       clk = 1'b0;
  logic       rst4, rst2;
  logic [3:0] t4;
  logic [7:0] s4;
  logic [1:0] act4, ph4;
  logic [1:0] t2;
  logic [3:0] s2;
  logic [0:0] act2;
  logic [1:0] ph2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  traffic_signal_rr #(.N_DIR(4), .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_CYC(2), .ALL_RED_CYC(3)) u4 (
    .clk(clk), .reset(rst4), .T(t4), .S(s4), .active(act4), .phase(ph4));

  traffic_signal_rr #(.N_DIR(2), .MIN_GREEN(1), .MAX_GREEN(16), .YELLOW_CYC(1), .ALL_RED_CYC(1)) u2 (
    .clk(clk), .reset(rst2), .T(t2), .S(s2), .active(act2), .phase(ph2));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset across one edge with the given sensors, then releases just after an edge.
  task automatic restart4(input logic [3:0] t);
    rst4 = 1'b0;
    t4   = t;
    step(1);
    rst4 = 1'b1;
  endtask

  task automatic test_reset;
    rst4 = 1'b0;
    t4   = 4'b1111;
    step(3);
    total_cnt++;
    if (s4 !== 8'b10101000) $display("FAIL reset_S actual=%b required=%b", s4, 8'b10101000);
    else pass_cnt++;
    total_cnt++;
    if (act4 !== 2'd0) $display("FAIL reset_active actual=%0d required=0", act4);
    else pass_cnt++;
    total_cnt++;
    if (ph4 !== 2'b00) $display("FAIL reset_phase actual=%b required=00", ph4);
    else pass_cnt++;
    rst4 = 1'b1;
    step(5);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd0)
      $display("FAIL reset_release_hold actual=ph%b/a%0d required=ph00/a0", ph4, act4);
    else pass_cnt++;
  endtask

  task automatic test_ping_pong;
    rst2 = 1'b0;
    t2   = 2'b10;
    step(1);
    rst2 = 1'b1;
    step(1);
    total_cnt++;
    if (ph2 !== 2'b01 || s2 !== 4'b1001)
      $display("FAIL pp_yellow0 actual=ph%b/S%b required=ph01/S1001", ph2, s2);
    else pass_cnt++;
    step(1 + AR2);
    total_cnt++;
    if (ph2 !== 2'b00 || act2 !== 1'b1 || s2 !== 4'b0010)
      $display("FAIL pp_green1 actual=ph%b/a%0d/S%b required=ph00/a1/S0010", ph2, act2, s2);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (ph2 !== 2'b00 || act2 !== 1'b1)
      $display("FAIL pp_hold1 actual=ph%b/a%0d required=ph00/a1", ph2, act2);
    else pass_cnt++;
    t2 = 2'b00;
    step(1);
    total_cnt++;
    if (s2 !== 4'b0110) $display("FAIL pp_yellow1 actual=%b required=0110", s2);
    else pass_cnt++;
    step(1 + AR2);
    total_cnt++;
    if (ph2 !== 2'b00 || act2 !== 1'b0 || s2 !== 4'b1000)
      $display("FAIL pp_back0 actual=ph%b/a%0d/S%b required=ph00/a0/S1000", ph2, act2, s2);
    else pass_cnt++;
  endtask

  task automatic test_min_green;
    restart4(4'b0001);
    step(1);
    t4 = 4'b0000;
    step(2);
    total_cnt++;
    if (ph4 !== 2'b00) $display("FAIL min_green_hold actual=%b required=00", ph4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01 || s4 !== 8'b10101001)
      $display("FAIL min_green_yellow actual=ph%b/S%b required=ph01/S10101001", ph4, s4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01) $display("FAIL yellow_len actual=%b required=01", ph4);
    else pass_cnt++;
    step(1 + AR4);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd1 || s4 !== 8'b10100010)
      $display("FAIL idle_next actual=ph%b/a%0d/S%b required=ph00/a1/S10100010", ph4, act4, s4);
    else pass_cnt++;
  endtask

  task automatic test_max_green;
    restart4(4'b0101);
    step(9);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd0)
      $display("FAIL max_green_cycle9 actual=ph%b/a%0d required=ph00/a0", ph4, act4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01) $display("FAIL max_green_preempt actual=%b required=01", ph4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01) $display("FAIL max_yellow2 actual=%b required=01", ph4);
    else pass_cnt++;
    step(1 + AR4);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd2 || s4 !== 8'b10001010)
      $display("FAIL max_next actual=ph%b/a%0d/S%b required=ph00/a2/S10001010", ph4, act4, s4);
    else pass_cnt++;
  endtask

  task automatic test_rr_skip;
    restart4(4'b0010);
    step(4);
    total_cnt++;
    if (ph4 !== 2'b01 || act4 !== 2'd0)
      $display("FAIL rr_yellow0 actual=ph%b/a%0d required=ph01/a0", ph4, act4);
    else pass_cnt++;
    step(2 + AR4);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd1)
      $display("FAIL rr_green1 actual=ph%b/a%0d required=ph00/a1", ph4, act4);
    else pass_cnt++;
    t4 = 4'b1001;
    step(3);
    total_cnt++;
    if (ph4 !== 2'b00) $display("FAIL rr_min_green1 actual=%b required=00", ph4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01 || act4 !== 2'd1)
      $display("FAIL rr_yellow1 actual=ph%b/a%0d required=ph01/a1", ph4, act4);
    else pass_cnt++;
    step(2 + AR4);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd3 || s4 !== 8'b00101010)
      $display("FAIL rr_skip_to3 actual=ph%b/a%0d/S%b required=ph00/a3/S00101010", ph4, act4, s4);
    else pass_cnt++;

    restart4(4'b0010);
    step(6 + AR4);
    t4 = 4'b0000;
    step(4);
    total_cnt++;
    if (ph4 !== 2'b01 || act4 !== 2'd1)
      $display("FAIL rr_idle_yellow1 actual=ph%b/a%0d required=ph01/a1", ph4, act4);
    else pass_cnt++;
    step(2 + AR4);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd2)
      $display("FAIL rr_idle_to2 actual=ph%b/a%0d required=ph00/a2", ph4, act4);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    restart4(4'b0000);
    step(4);
    #2;
    rst4 = 1'b0;
    #1;
    total_cnt++;
    if (s4 !== 8'b10101000 || ph4 !== 2'b00 || act4 !== 2'd0)
      $display("FAIL async_reset actual=S%b/ph%b/a%0d required=S10101000/ph00/a0", s4, ph4, act4);
    else pass_cnt++;
    step(1);
    rst4 = 1'b1;
    step(3);
    total_cnt++;
    if (ph4 !== 2'b00) $display("FAIL reset_tmr_clear actual=%b required=00", ph4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b01) $display("FAIL reset_resume_yellow actual=%b required=01", ph4);
    else pass_cnt++;
  endtask

`ifdef ALL_RED_EN
  task automatic test_all_red;
    restart4(4'b0000);
    step(6);
    total_cnt++;
    if (ph4 !== 2'b10 || s4 !== 8'b10101010)
      $display("FAIL all_red_enter actual=ph%b/S%b required=ph10/S10101010", ph4, s4);
    else pass_cnt++;
    step(2);
    total_cnt++;
    if (ph4 !== 2'b10 || s4 !== 8'b10101010)
      $display("FAIL all_red_len actual=ph%b/S%b required=ph10/S10101010", ph4, s4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ph4 !== 2'b00 || act4 !== 2'd1)
      $display("FAIL all_red_exit actual=ph%b/a%0d required=ph00/a1", ph4, act4);
    else pass_cnt++;
    restart4(4'b0000);
    step(7);
    #2;
    rst4 = 1'b0;
    #1;
    total_cnt++;
    if (s4 !== 8'b10101000 || ph4 !== 2'b00 || act4 !== 2'd0)
      $display("FAIL all_red_reset actual=S%b/ph%b/a%0d required=S10101000/ph00/a0", s4, ph4, act4);
    else pass_cnt++;
    step(1);
    rst4 = 1'b1;
  endtask
`else
  task automatic test_no_all_red;
    restart4(4'b0101);
    for (int i = 0; i < 30; i++) begin
      step(1);
      total_cnt++;
      if (ph4 === 2'b10 || s4 === 8'b10101010)
        $display("FAIL no_all_red cycle=%0d actual=ph%b/S%b required=ph!=10", i, ph4, s4);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    rst4 = 1'b0;
    rst2 = 1'b0;
    t4   = 4'b0000;
    t2   = 2'b00;
    step(1);
    test_reset;
    test_ping_pong;
    test_min_green;
    test_max_green;
    test_rr_skip;
    test_async_reset;
`ifdef ALL_RED_EN
    test_all_red;
`else
    test_no_all_red;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
